// File: rtl/mips_fetch_if.sv
// Fetch unit bus bundle: instruction memory port, redirect
// input and the instruction stream handed to decode.
interface mips_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output inst_out, inst_pc, inst_valid,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  inst_out, inst_pc, inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: one outstanding memory read at a time,
// results buffered in a small {pc, inst} FIFO for decode.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  mips_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic          run;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;
  logic          valid, push, pop, has_space;
  logic [31:0]   tgt_pc;
  logic          unused_pc_lsb;

  assign tgt_pc = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  assign valid = count != '0;
  assign push  = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign pop   = valid && bus.inst_ready && !bus.redirect;

  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign has_space = count_nxt < FULL;

  assign bus.imem_req   = state == REQ;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = valid;
  assign bus.inst_out   = valid ? inst_mem[rd_ptr] : '0;
  assign bus.inst_pc    = valid ? pc_mem[rd_ptr] : '0;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    unique case (1'b1)
      (state == IDLE): begin
        if (bus.redirect) begin
          pc_nxt = tgt_pc;
        end else if (run && count < FULL) begin
          state_nxt = REQ;
        end
      end
      (state == REQ): begin
        if (bus.redirect) begin
          pc_nxt    = tgt_pc;
          state_nxt = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = has_space ? REQ : IDLE;
        end
      end
      (state == DROP): begin
        if (bus.redirect) begin
          pc_nxt = tgt_pc;
        end
        // the stale ack retires the old request even alongside a redirect
        if (bus.imem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: scoreboard of expected {pc, inst}
// pairs, drained by a monitor on every accepted instruction.
module tb_mips_fetch_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_fetch_if bus();
  mips_fetch_if w();

  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        auto_en = 1'b0;
  int          ack_wait = 1;
  int          ack_cnt = 0;
  logic        w_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
  endfunction

  assign bus.imem_ack    = auto_ack | man_ack;
  assign bus.imem_rdata  = man_ack ? man_rdata : auto_rdata;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;
  assign bus.inst_ready  = ready;

  assign w.imem_ack    = w.imem_req;
  assign w.imem_rdata  = memf(w.imem_addr);
  assign w.redirect    = 1'b0;
  assign w.redirect_pc = '0;
  assign w.inst_ready  = w_ready;

  mips_fetch_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mips_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (w)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_pc(logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = memf(pc);
    exp_q.push_back(e);
  endtask

  // memory model: latches the request, answers ack_wait cycles later
  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          wcnt;
    pend  = 1'b0;
    paddr = '0;
    wcnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      auto_ack = 1'b0;
      if (rst || !auto_en) begin
        pend = 1'b0;
        if (rst) ack_cnt = 0;
      end else begin
        if (!pend && bus.imem_req) begin
          pend  = 1'b1;
          paddr = bus.imem_addr;
          wcnt  = 0;
        end
        if (pend) begin
          if (wcnt >= ack_wait) begin
            auto_ack   = 1'b1;
            auto_rdata = memf(paddr);
            pend       = 1'b0;
            ack_cnt++;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.inst_valid && bus.inst_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop pc=%h inst=%h",
                   bus.inst_pc, bus.inst_out);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", bus.inst_pc, e.pc);
          chk("pop_inst", bus.inst_out, e.inst);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst      = 1'b1;
    auto_en  = 1'b0;
    ready    = 1'b0;
    redirect = 1'b0;
    man_ack  = 1'b0;
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    chk("drain_left", exp_q.size(), 0);
    ready = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !bus.imem_req; i++) step();
    chk("req_seen", {31'b0, bus.imem_req}, 1);
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 0);
    chk("rst_valid", {31'b0, bus.inst_valid}, 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_inst", bus.inst_out, 32'h0);
    chk("rst_ipc", bus.inst_pc, 32'h0);
    chk("rst_waddr", w.imem_addr, 32'hFFFF_FFF8);
    step();
    rst = 1'b0;
    step();
    chk("first_edge_req", {31'b0, bus.imem_req}, 0);

    // sequential stream with ready held high
    auto_en  = 1'b1;
    ack_wait = 1;
    ready    = 1'b1;
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    step();
    chk("first_req", {31'b0, bus.imem_req}, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    drain(100);

    // backpressure: fill to four, one pop restarts fetch
    do_reset();
    auto_en  = 1'b1;
    ack_wait = 1;
    repeat (30) step();
    chk("full_acks", ack_cnt, 4);
    chk("full_req", {31'b0, bus.imem_req}, 0);
    chk("full_head", bus.inst_pc, 32'h0);
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_0001;
    step();
    man_ack = 1'b0;
    step();
    chk("idle_ack_head", bus.inst_out, memf(32'h0));
    expect_pc(32'h0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("pop_one_acks", ack_cnt, 4);
    chk("pop_one_head", bus.inst_pc, 32'h4);
    step();
    chk("refill_req", {31'b0, bus.imem_req}, 1);
    chk("refill_addr", bus.imem_addr, 32'h10);
    for (int i = 1; i <= 4; i++) expect_pc(32'(i * 4));
    ready = 1'b1;
    drain(60);

    // redirect with request outstanding, late stale ack
    do_reset();
    wait_req();
    chk("r1_addr", bus.imem_addr, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("drop_req0", {31'b0, bus.imem_req}, 0);
    step();
    chk("drop_req1", {31'b0, bus.imem_req}, 0);
    step();
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    chk("drop_req2", {31'b0, bus.imem_req}, 0);
    step();
    man_ack = 1'b0;
    chk("drop_done_req", {31'b0, bus.imem_req}, 0);
    step();
    chk("r1_new_req", {31'b0, bus.imem_req}, 1);
    chk("r1_new_addr", bus.imem_addr, 32'h100);
    chk("r1_no_valid", {31'b0, bus.inst_valid}, 0);
    expect_pc(32'h100);
    expect_pc(32'h104);
    expect_pc(32'h108);
    auto_en = 1'b1;
    ready   = 1'b1;
    drain(60);

    // redirect coincident with ack
    do_reset();
    wait_req();
    man_ack     = 1'b1;
    man_rdata   = 32'hBAD0_0BAD;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0202;
    step();
    man_ack  = 1'b0;
    redirect = 1'b0;
    chk("r2_req0", {31'b0, bus.imem_req}, 0);
    chk("r2_valid", {31'b0, bus.inst_valid}, 0);
    step();
    chk("r2_req1", {31'b0, bus.imem_req}, 1);
    chk("r2_addr", bus.imem_addr, 32'h200);
    expect_pc(32'h200);
    expect_pc(32'h204);
    auto_en = 1'b1;
    ready   = 1'b1;
    drain(60);

    // async reset with three entries and a request in flight
    do_reset();
    auto_en  = 1'b1;
    ack_wait = 2;
    for (int i = 0; i < 40 && ack_cnt < 3; i++) step();
    step();
    chk("pre_valid", {31'b0, bus.inst_valid}, 1);
    chk("pre_req", {31'b0, bus.imem_req}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", {31'b0, bus.inst_valid}, 0);
    chk("async_req", {31'b0, bus.imem_req}, 0);
    chk("async_addr", bus.imem_addr, 32'h0);
    auto_en = 1'b0;
    exp_q.delete();
    repeat (2) step();
    rst      = 1'b0;
    auto_en  = 1'b1;
    ack_wait = 1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    ready = 1'b1;
    drain(60);

    // RESET_PC near the top of the address space wraps to zero
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] p;
      p = 32'hFFFF_FFF8 + 32'(i * 4);
      chk("wrap_valid", {31'b0, w.inst_valid}, 1);
      chk("wrap_pc", w.inst_pc, p);
      chk("wrap_inst", w.inst_out, memf(p));
      w_ready = 1'b1;
      step();
      w_ready = 1'b0;
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction buffer entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  one-cycle pulse; flush and restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0.
REQ-011 inst_out  output  32  instruction word presented to the decode/register-read stage.
REQ-012 inst_pc  output  32  address of inst_out.
REQ-013 inst_valid  output  1  inst_out and inst_pc are valid.
REQ-014 inst_ready  input  1  consumer accepts inst_out this cycle.

Function
REQ-015 The block SHALL keep a fetch PC register, a FIFO of {pc, instruction} pairs, and a 3-state FSM: IDLE, REQ, DROP.
REQ-016 At most one memory request SHALL be outstanding at any time.
REQ-017 IDLE->REQ: when no redirect is present and (FIFO occupancy + 1) <= FIFO_DEPTH; imem_req then asserts on the next cycle with imem_addr = PC.
REQ-018 In REQ, imem_req and imem_addr SHALL hold stable until imem_ack.
REQ-019 REQ + imem_ack (no redirect): push {PC, imem_rdata}; PC <= PC + 4; go to REQ if space remains after the push (counting a same-cycle pop), otherwise go to IDLE.
REQ-020 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-021 inst_valid = FIFO not empty; inst_out and inst_pc = FIFO head; pop on inst_valid && inst_ready.
REQ-022 Push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-023 No push SHALL occur into a full FIFO (guaranteed by REQ-017); a pop from an empty FIFO SHALL be ignored.
REQ-024 On redirect, the FIFO SHALL flush and PC <= {redirect_pc[31:2], 2'b00}, both effective the next cycle; a same-cycle pop is irrelevant.
REQ-025 Redirect in REQ without imem_ack: go to DROP and deassert imem_req.
REQ-026 In DROP, the next imem_ack SHALL be discarded (no push, PC unchanged), then go to IDLE.
REQ-027 Redirect in REQ coinciding with imem_ack: discard the ack data and go to IDLE (not DROP).
REQ-028 Redirect in IDLE: go to IDLE with the new PC.
REQ-029 Redirect in DROP: update PC only; remain in DROP.
REQ-030 imem_ack while in IDLE SHALL be ignored.
REQ-031 inst_valid SHALL never assert for an instruction fetched before the most recent redirect.

Reset
REQ-032 While rst is high: state = IDLE, PC = RESET_PC, FIFO empty, imem_req = 0, inst_valid = 0, imem_addr = RESET_PC, inst_out = 0, inst_pc = 0.
REQ-033 Assertion of rst mid-request SHALL abandon the request with no DROP; the bench SHALL not deliver a stale ack after reset.
REQ-034 First imem_req SHALL assert no earlier than the second rising edge after rst deasserts.

Verification
REQ-035 Reset release, ack one cycle after each request, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8, ...; inst_out matches imem_rdata in order.
REQ-036 inst_ready=0, acks always given -> exactly 4 pushes, imem_req stays low; then inst_ready=1 for one cycle -> one pop and one new request, to 0x10.
REQ-037 Redirect to 0x0000_0103 while a request is outstanding, ack 3 cycles later -> that ack is dropped; next imem_addr = 0x0000_0100; first inst_pc after redirect = 0x100.
REQ-038 Redirect coincident with imem_ack -> no push; next request to the redirect target; no DROP cycle.
REQ-039 RESET_PC = 32'hFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 rst pulsed while FIFO holds 3 entries and a request is outstanding -> inst_valid = 0 and imem_req = 0 immediately (async); fetch restarts at RESET_PC.
